// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: default sizing,
// register word addresses and the source ID type.
package irq_ctrl_pkg;

  localparam int NUM_SRC_DEF = 8;
  localparam int PRIO_W_DEF  = 3;

  typedef logic [4:0] id_t;

  localparam logic [4:0] ADDR_PENDING   = 5'h00;
  localparam logic [4:0] ADDR_ENABLE    = 5'h04;
  localparam logic [4:0] ADDR_THRESHOLD = 5'h08;
  localparam logic [4:0] ADDR_CLAIM     = 5'h0C;
  localparam logic [4:0] ADDR_PRIORITY  = 5'h10;

  // Byte address to word-aligned register address.
  function automatic logic [4:0] word_addr(input logic [4:0] a);
    return {a[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: 2-flop synchronizer, sticky pending bit and in-service
// bit. A claim always wins over a same-cycle re-assertion of the source.
module irq_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic i_src,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending,
  output logic o_in_service
);

  logic r_sync1;
  logic r_sync2;
  logic r_pending;
  logic r_in_service;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_pending    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
      if (i_claim) begin
        r_pending    <= 1'b0;
        r_in_service <= 1'b1;
      end else begin
        if (r_sync2 && !r_in_service) r_pending <= 1'b1;
        if (i_complete) r_in_service <= 1'b0;
      end
    end
  end

  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source gateways, register file, priority-based
// winner selection, claim/complete handshake and registered core interrupt.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int PRIO_W  = PRIO_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               sel_i,
  input  logic               we_i,
  input  logic [4:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               irq_ext_o
);

  localparam int PW = NUM_SRC * PRIO_W;

  logic [NUM_SRC-1:0] r_enable;
  logic [PRIO_W-1:0]  r_threshold;
  logic [PRIO_W-1:0]  r_prio [NUM_SRC];
  logic [31:0]        r_rdata;
  logic               r_irq;

  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_in_service;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_claim;
  logic [NUM_SRC-1:0] w_complete;
  logic [PW+31:0]     w_prio_pad;
  logic [PW+31:0]     w_wdata_pad;
  logic [31:0]        w_rd_data;
  logic [4:0]         w_waddr;
  logic               w_rd;
  logic               w_wr;
  id_t                w_win_id;
  logic [PRIO_W-1:0]  w_win_prio;
  logic               w_unused_ok;

  assign w_waddr     = word_addr(addr_i);
  assign w_rd        = sel_i & ~we_i;
  assign w_wr        = sel_i & we_i;
  assign w_wdata_pad = {{PW{1'b0}}, wdata_i};
  assign w_prio_pad[PW +: 32] = '0;
  assign w_unused_ok = ^{addr_i[1:0], w_wdata_pad, w_prio_pad, w_in_service};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_gateway u_gw (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_src        (irq_src_i[g]),
      .i_claim      (w_claim[g]),
      .i_complete   (w_complete[g]),
      .o_pending    (w_pending[g]),
      .o_in_service (w_in_service[g])
    );
    assign w_eligible[g] = w_pending[g] & r_enable[g] & (r_prio[g] > r_threshold);
    assign w_claim[g]    = w_rd && (w_waddr == ADDR_CLAIM) && (w_win_id == id_t'(g + 1));
    assign w_complete[g] = w_wr && (w_waddr == ADDR_CLAIM) && (wdata_i[4:0] == id_t'(g + 1));
    assign w_prio_pad[g*PRIO_W +: PRIO_W] = r_prio[g];
  end

  // Strictly-greater compare keeps the lowest ID on a priority tie.
  always_comb begin
    w_win_id   = '0;
    w_win_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_eligible[i] && (r_prio[i] > w_win_prio)) begin
        w_win_prio = r_prio[i];
        w_win_id   = id_t'(i + 1);
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (w_waddr)
      ADDR_PENDING:   w_rd_data[NUM_SRC-1:0] = w_pending;
      ADDR_ENABLE:    w_rd_data[NUM_SRC-1:0] = r_enable;
      ADDR_THRESHOLD: w_rd_data[PRIO_W-1:0]  = r_threshold;
      ADDR_CLAIM:     w_rd_data[4:0]         = w_win_id;
      ADDR_PRIORITY:  w_rd_data              = w_prio_pad[31:0];
      default:        w_rd_data              = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable    <= '0;
      r_threshold <= '0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
    end else begin
      r_irq <= |w_eligible;
      if (w_rd) r_rdata <= w_rd_data;
      if (w_wr) begin
        case (w_waddr)
          ADDR_ENABLE:    r_enable    <= wdata_i[NUM_SRC-1:0];
          ADDR_THRESHOLD: r_threshold <= wdata_i[PRIO_W-1:0];
          ADDR_PRIORITY: begin
            // Only sources whose field fits in the 32-bit word are writable.
            for (int i = 0; i < NUM_SRC; i++) begin
              if (i * PRIO_W + PRIO_W <= 32) r_prio[i] <= w_wdata_pad[i*PRIO_W +: PRIO_W];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rdata_o   = r_rdata;
  assign irq_ext_o = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register table, directed claim/complete/reset scenarios
// and a randomized run checked against a behavioural reference model.
module tb_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_src_i;
  logic        sel_i;
  logic        we_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        irq_ext_o;

  int n_cmp = 0;
  int n_err = 0;

  irq_ctrl #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src_i (irq_src_i),
    .sel_i     (sel_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .irq_ext_o (irq_ext_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit       m_pend [8];
  bit       m_serv [8];
  bit       m_en   [8];
  int       m_prio [8];
  int       m_thr;
  bit [7:0] m_s1, m_s2;
  logic [31:0] m_rdata;
  bit       m_irq;

  function automatic bit m_elig(int i);
    return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
  endfunction

  // Highest priority first, then lowest ID.
  function automatic int m_winner();
    for (int p = 7; p >= 1; p--)
      for (int i = 0; i < 8; i++)
        if (m_elig(i) && m_prio[i] == p) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_reg(int a, int win);
    logic [31:0] v;
    v = 0;
    case (a)
      0: for (int i = 0; i < 8; i++) v[i] = m_pend[i];
      1: for (int i = 0; i < 8; i++) v[i] = m_en[i];
      2: v = m_thr;
      3: v = win;
      4: for (int i = 0; i < 8; i++) v = v | (m_prio[i] << (3 * i));
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 0; m_serv[i] = 0; m_en[i] = 0; m_prio[i] = 0;
    end
    m_thr = 0; m_s1 = 0; m_s2 = 0; m_rdata = 0; m_irq = 0;
  endtask

  task automatic m_step(bit sel, bit we, logic [4:0] addr, logic [31:0] wd, logic [7:0] src);
    int  win, a, c, d;
    bit  any;
    bit  np [8];
    win = m_winner();
    any = (win != 0);
    a   = int'(addr) >> 2;
    c   = (sel && !we && a == 3) ? win : 0;
    d   = (sel && we && a == 3) ? int'(wd[4:0]) : 0;
    if (sel && !we) m_rdata = m_reg(a, win);
    for (int i = 0; i < 8; i++)
      np[i] = (c == i + 1) ? 1'b0 : (m_pend[i] || (m_s2[i] && !m_serv[i]));
    for (int i = 0; i < 8; i++) begin
      if (c == i + 1) m_serv[i] = 1;
      else if (d == i + 1) m_serv[i] = 0;
      m_pend[i] = np[i];
    end
    m_s2  = m_s1;
    m_s1  = src;
    m_irq = any;
    if (sel && we) begin
      if (a == 1) for (int i = 0; i < 8; i++) m_en[i] = wd[i];
      if (a == 2) m_thr = int'(wd[2:0]);
      if (a == 4) for (int i = 0; i < 8; i++) m_prio[i] = int'((wd >> (3 * i)) & 32'h7);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_clear();
    else m_step(sel_i, we_i, addr_i, wdata_i, irq_src_i);
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk);
    sel_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk);
    sel_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic do_reset();
    irq_src_i = '0; sel_i = 1'b0; we_i = 1'b0;
    rst_n = 1'b0;
    tick(2);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_irq", {31'b0, irq_ext_o}, 32'h0);
    rst_n = 1'b1;
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] d;
    logic [4:0]  a;
    int          r, idx;

    rst_n = 1'b1; irq_src_i = '0; sel_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    @(negedge clk);
    do_reset();

    tbl.push_back('{1'b1, 5'h04, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b0, 5'h04, 32'h0, 32'h0000_00FF});
    tbl.push_back('{1'b1, 5'h08, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b0, 5'h08, 32'h0, 32'h0000_0007});
    tbl.push_back('{1'b1, 5'h10, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b0, 5'h10, 32'h0, 32'h00FF_FFFF});
    tbl.push_back('{1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b0, 5'h00, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 5'h14, 32'h0000_1234, 32'h0});
    tbl.push_back('{1'b0, 5'h14, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'h1C, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'h07, 32'h0, 32'h0000_00FF});
    tbl.push_back('{1'b0, 5'h0C, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 5'h04, 32'h0000_005A, 32'h0});
    tbl.push_back('{1'b0, 5'h06, 32'h0, 32'h0000_005A});

    foreach (tbl[i]) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
      else begin
        rd(tbl[i].addr, d);
        check($sformatf("tbl[%0d]", i), d, tbl[i].exp);
      end
    end
    wr(5'h08, 32'h3);
    tick(2);
    check("rdata_hold", rdata_o, 32'h0000_005A);

    // Single pulse on src0, claim, irq drops.
    do_reset();
    wr(5'h04, 32'h01); wr(5'h10, 32'h3); wr(5'h08, 32'h0);
    irq_src_i = 8'h01; tick(1); irq_src_i = 8'h00; tick(3);
    rd(5'h00, d); check("pulse_pending", d, 32'h01);
    check("pulse_irq", {31'b0, irq_ext_o}, 32'h1);
    rd(5'h0C, d); check("pulse_claim", d, 32'd1);
    tick(1);
    check("pulse_irq_drop", {31'b0, irq_ext_o}, 32'h0);
    rd(5'h00, d); check("pulse_pending_clr", d, 32'h0);

    // Equal-priority tie goes to the lower ID.
    do_reset();
    wr(5'h04, 32'h24); wr(5'h10, (32'd5 << 6) | (32'd5 << 15));
    irq_src_i = 8'h24; tick(4);
    rd(5'h0C, d); check("tie_claim_a", d, 32'd3);
    wr(5'h0C, 32'd3);
    rd(5'h0C, d); check("tie_claim_b", d, 32'd6);
    wr(5'h0C, 32'd6);

    // Threshold masking.
    do_reset();
    wr(5'h04, 32'h02); wr(5'h10, 32'd2 << 3); wr(5'h08, 32'd2);
    irq_src_i = 8'h02; tick(5);
    check("thr_irq_low", {31'b0, irq_ext_o}, 32'h0);
    rd(5'h0C, d); check("thr_claim_none", d, 32'd0);
    wr(5'h08, 32'd1);
    check("thr_irq_not_yet", {31'b0, irq_ext_o}, 32'h0);
    tick(1);
    check("thr_irq_high", {31'b0, irq_ext_o}, 32'h1);

    // Held source: no re-pend while in service, re-pend after complete.
    do_reset();
    wr(5'h04, 32'h08); wr(5'h10, 32'd1 << 9);
    irq_src_i = 8'h08; tick(4);
    rd(5'h0C, d); check("held_claim", d, 32'd4);
    tick(3);
    rd(5'h00, d); check("held_in_service", d, 32'h0);
    wr(5'h0C, 32'd4); tick(1);
    rd(5'h00, d); check("held_repend", d, 32'h08);
    wr(5'h0C, 32'd7);
    rd(5'h00, d); check("bogus_complete", d, 32'h08);
    check("bogus_irq", {31'b0, irq_ext_o}, 32'h1);
    rd(5'h0C, d); check("reclaim", d, 32'd4);

    // Reset with one source in service and another pending.
    do_reset();
    wr(5'h04, 32'h11); wr(5'h10, 32'h1 | (32'h1 << 12));
    irq_src_i = 8'h01; tick(4);
    rd(5'h0C, d); check("mid_claim", d, 32'd1);
    irq_src_i = 8'h11; tick(4);
    rd(5'h00, d); check("mid_pending", d, 32'h10);
    irq_src_i = 8'h01;
    rst_n = 1'b0; tick(2);
    check("mid_rst_rdata", rdata_o, 32'h0);
    check("mid_rst_irq", {31'b0, irq_ext_o}, 32'h0);
    rst_n = 1'b1;
    rd(5'h00, d); check("post_rst_pending", d, 32'h0);
    rd(5'h04, d); check("post_rst_enable", d, 32'h0);
    rd(5'h08, d); check("post_rst_thr", d, 32'h0);
    rd(5'h10, d); check("post_rst_prio", d, 32'h0);
    check("post_rst_irq", {31'b0, irq_ext_o}, 32'h0);
    wr(5'h04, 32'h01); wr(5'h10, 32'h1); tick(1);
    rd(5'h00, d); check("post_rst_repend", d, 32'h01);
    rd(5'h0C, d); check("post_rst_claim", d, 32'd1);

    // Randomized run against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 3) == 0) irq_src_i = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r < 4) begin
        sel_i = 1'b0; we_i = 1'b0;
      end else begin
        idx = $urandom_range(0, 9);
        if (idx >= 5 && idx <= 7) idx = 3;
        else if (idx == 8) idx = 5;
        else if (idx == 9) idx = 7;
        a = {idx[2:0], 2'($urandom_range(0, 3))};
        sel_i  = 1'b1;
        we_i   = (r >= 8);
        addr_i = a;
        if (idx == 3)      wdata_i = 32'($urandom_range(0, 9));
        else if (idx == 2) wdata_i = 32'($urandom_range(0, 3));
        else               wdata_i = $urandom;
      end
      @(negedge clk);
      check("rand_rdata", rdata_o, m_rdata);
      check("rand_irq", {31'b0, irq_ext_o}, {31'b0, m_irq});
    end
    sel_i = 1'b0; we_i = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8: number of external interrupt sources (1..31).
REQ-002 Parameter PRIO_W, default 3: priority field width; priority 0 means never interrupt.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 irq_src_i  input  NUM_SRC  level-sensitive sources, asynchronous to clk; bit i is source ID i+1.
REQ-006 sel_i  input  1  register access strobe, single cycle.
REQ-007 we_i  input  1  1 = write, 0 = read; qualified by sel_i.
REQ-008 addr_i  input  5  byte address; bits [1:0] are ignored.
REQ-009 wdata_i  input  32  write data.
REQ-010 rdata_o  output  32  read data, valid exactly one cycle after the sel_i read cycle.
REQ-011 irq_ext_o  output  1  interrupt request to the core's irq_ext_i.

Function
REQ-012 Each source passes through a 2-flop synchronizer before the gateway; total input latency is 2 cycles.
REQ-013 Register map, all addresses byte: 0x00 PENDING (RO), 0x04 ENABLE (RW), 0x08 THRESHOLD (RW, PRIO_W bits), 0x0C CLAIM/COMPLETE, 0x10 PRIORITY (RW, source i at bits [PRIO_W*i+PRIO_W-1:PRIO_W*i]).
REQ-014 Unused or unmapped bits read 0; writes to 0x00 and to unmapped addresses are ignored.
REQ-015 Gateway per source: pending[i] sets when the synchronized source is 1 and in_service[i] is 0; pending is sticky until claimed.
REQ-016 Eligible(i): pending[i] && enable[i] && priority[i] > threshold.
REQ-017 Winner: the eligible source with the highest priority; ties go to the lowest ID; ID 0 means none eligible.
REQ-018 irq_ext_o is registered: it is 1 in the cycle after any source is eligible, and 0 in the cycle after none is.
REQ-019 Read of 0x0C (claim): rdata_o = winner ID; in the same cycle, if the ID is nonzero, pending[ID-1] clears and in_service[ID-1] sets.
REQ-020 Write of 0x0C (complete): if wdata_i[4:0] names a source with in_service set, in_service clears; otherwise the write is ignored.
REQ-021 A source held high after complete re-pends on the following cycle.
REQ-022 Source asserted in the same cycle its claim occurs: the claim wins; pending stays 0 while in service.
REQ-023 Disabling or reprioritising a pending source does not clear its pending bit.
REQ-024 Multiple sources may be in service at once; each completes independently.
REQ-025 Read while sel_i is 0: rdata_o holds its previous value.

Reset
REQ-026 Reset clears the synchronizers, pending, in_service, ENABLE, PRIORITY and THRESHOLD, and sets rdata_o = 0 and irq_ext_o = 0.
REQ-027 Reset mid-service drops all in-service state; no complete is required afterwards.
REQ-028 After rst_n deasserts, the first pending bit can appear no earlier than 3 clk edges later.

Structure
REQ-029 irq_ctrl_pkg holds NUM_SRC and PRIO_W defaults, the register address constants, and an id_t typedef (5 bits).
REQ-030 One sub-module, irq_gateway, is instantiated NUM_SRC times; it contains the synchronizer, pending and in_service for one source.
REQ-031 Winner selection is a combinational priority tree in irq_ctrl; no other sub-modules.

Verification
REQ-032 Setup ENABLE=0x01, PRIO[0]=3, THR=0; pulse src0 high for 1 cycle -> PENDING=0x01 and irq_ext_o=1; claim returns 1; irq_ext_o=0 one cycle after the claim.
REQ-033 Enable src2 (prio 5) and src5 (prio 5), assert both -> claim returns 3; complete 3; next claim returns 6.
REQ-034 src1 has prio 2 and THR=2 -> irq_ext_o stays 0 and claim returns 0; set THR=1 -> irq_ext_o=1 one cycle later.
REQ-035 src3 held high, claim returns 4, no complete -> PENDING bit 3 stays 0; complete 4 -> PENDING bit 3 =1 next cycle; complete 7 while not in service -> no state change.
REQ-036 Assert rst_n low with src0 in service and src4 pending -> all registers read 0, irq_ext_o=0; after reset, with src0 still high and re-enabled -> it pends again.
